// File: rtl/zigbee_frame_ctrl.sv
// zigbee_frame_ctrl: 802.15.4 receive framer gating PSDU nibbles from the CDR into the FIFO.
// Defining FRAME_CRC_EN adds a CRC-16 FCS check driving o_crc_ok.
module zigbee_frame_ctrl #(
    parameter int PRE_MIN_BITS = 32,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_en,
    input  logic       i_cdr_data,
    input  logic       i_cdr_flag,
    input  logic       i_fifo_full,
    output logic       o_fifo_wr_en,
    output logic [3:0] o_fifo_data,
    output logic       o_frame_active,
    output logic       o_frame_done,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic [6:0] o_len,
    output logic       o_crc_ok
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {HUNT_PRE, HUNT_SFD, LEN, PAYLOAD} state_e;

    state_e        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_q, wr_d, done_q, done_d, err_q, err_d, ok_q, ok_d;
    logic [3:0]    data_q, data_d;
    logic [1:0]    code_q, code_d, abort;
    logic [6:0]    len_q, len_d;
    logic          in_frame, tmo_hit, ok_done;
`ifdef FRAME_CRC_EN
    logic [15:0]   crc_q, crc_d, crc_nx;
`endif

    assign in_frame = (state_q == LEN) || (state_q == PAYLOAD);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        wr_d    = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        len_d   = len_q;
        ok_d    = ok_q;
        abort   = 2'd0;
        tmo_hit = 1'b0;
`ifdef FRAME_CRC_EN
        crc_d   = crc_q;
        crc_nx  = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ i_cdr_data) ? 16'h8408 : 16'h0000);
        ok_done = (crc_nx == 16'h0000) && (len_q >= 7'd2);
`else
        ok_done = 1'b1;
`endif
        if (i_rx_en) begin
            if (i_cdr_flag)
                sr_d = {i_cdr_data, sr_q[7:1]};
            // a bit strobe always clears the timer, so it wins over a same-cycle timeout
            tmo_d   = (in_frame && !i_cdr_flag) ? tmo_q + 1'b1 : '0;
            tmo_hit = in_frame && !i_cdr_flag && (tmo_d == TW'(TIMEOUT_CYC));
            case (state_q)
                HUNT_PRE: if (i_cdr_flag) begin
                    cnt_d = i_cdr_data ? '0 : cnt_q + 10'd1;
                    if (!i_cdr_data && (cnt_q + 10'd1 == 10'(PRE_MIN_BITS))) begin
                        state_d = HUNT_SFD;
                        cnt_d   = '0;
                    end
                end
                HUNT_SFD: if (i_cdr_flag && (cnt_q != '0 || i_cdr_data)) begin
                    cnt_d = cnt_q + 10'd1;
                    if (sr_d == 8'hA7) begin
                        state_d = LEN;
                        cnt_d   = '0;
                        ok_d    = 1'b0;
`ifdef FRAME_CRC_EN
                        crc_d   = '0;
`endif
                    end else if (cnt_q == 10'd7) begin
                        state_d = HUNT_PRE;
                        cnt_d   = '0;
                    end
                end
                LEN: if (i_cdr_flag) begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'd7) begin
                        len_d   = sr_d[6:0];
                        cnt_d   = {sr_d[6:0], 3'b000};
                        state_d = PAYLOAD;
                        if (sr_d[6:0] == 7'd0)
                            abort = 2'd1;
                    end
                end else if (tmo_hit) begin
                    abort = 2'd3;
                end
                PAYLOAD: if (i_cdr_flag) begin
                    cnt_d = cnt_q - 10'd1;
`ifdef FRAME_CRC_EN
                    crc_d = crc_nx;
`endif
                    // cnt_q counts remaining bits; a nibble closes whenever cnt_q is 1 mod 4
                    if (cnt_q[1:0] == 2'd1) begin
                        if (i_fifo_full) begin
                            abort = 2'd2;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = sr_d[7:4];
                            if (cnt_q == 10'd1) begin
                                done_d  = 1'b1;
                                code_d  = 2'd0;
                                ok_d    = ok_done;
                                state_d = HUNT_PRE;
                                cnt_d   = '0;
                            end
                        end
                    end
                end else if (tmo_hit) begin
                    abort = 2'd3;
                end
                default: state_d = HUNT_PRE;
            endcase
            if (abort != 2'd0) begin
                err_d   = 1'b1;
                code_d  = abort;
                ok_d    = 1'b0;
                state_d = HUNT_PRE;
                cnt_d   = '0;
            end
        end else begin
            state_d = HUNT_PRE;
            cnt_d   = '0;
            sr_d    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HUNT_PRE;
            sr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            len_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            len_q   <= len_d;
            ok_q    <= ok_d;
        end
    end

`ifdef FRAME_CRC_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            crc_q <= '0;
        else
            crc_q <= crc_d;
    end
`endif

    assign o_fifo_wr_en   = wr_q;
    assign o_fifo_data    = data_q;
    assign o_frame_active = in_frame;
    assign o_frame_done   = done_q;
    assign o_frame_err    = err_q;
    assign o_err_code     = code_q;
    assign o_len          = len_q;
    assign o_crc_ok       = ok_q;
endmodule
